// File: rtl/da_vinci_bus_monitor_pkg.sv
// Shared definitions for the da_vinci bus monitor.
// Holds the FSM state encoding, default parameter values, project width
// constants and the saturating counter helper.
package da_vinci_bus_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } mon_state_e;

    localparam int COUNT_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 26;
    localparam int DEF_TRACE_DEPTH  = 16;
    localparam int DEF_IDLE_LIMIT   = 64;
    localparam int DEF_MAX_CYCLES   = 5000;
    localparam logic [31:0] DEF_WIN_LO = 32'h03ff_fff0;
    localparam logic [31:0] DEF_WIN_HI = 32'h03ff_ffff;

    // Transaction counters hold at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/da_vinci_trace_fifo.sv
// First-word-fall-through trace FIFO for the da_vinci bus monitor.
// The head word reads as zero while empty so the trace outputs are clean
// straight out of reset. A push while full succeeds only with a pop in the
// same cycle; a pop while empty is ignored. flush empties the FIFO.
module da_vinci_trace_fifo
    import da_vinci_bus_monitor_pkg::*;
#(
    parameter int WIDTH = 59,
    parameter int DEPTH = DEF_TRACE_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush takes priority over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only visible through valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/da_vinci_bus_monitor.sv
// da_vinci bus monitor: counts read/write strobe edges while armed, traces
// them into a FWFT FIFO, and stops on an idle halt or a cycle budget timeout.
// Optional feature: define DA_VINCI_BUS_MON_WINDOW_EN to trace only writes
// whose address falls inside [WIN_LO, WIN_HI]; counters are unaffected.
module da_vinci_bus_monitor
    import da_vinci_bus_monitor_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
    parameter int IDLE_LIMIT  = DEF_IDLE_LIMIT,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter logic [ADDR_WIDTH-1:0] WIN_LO = ADDR_WIDTH'(DEF_WIN_LO),
    parameter logic [ADDR_WIDTH-1:0] WIN_HI = ADDR_WIDTH'(DEF_WIN_HI)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [ADDR_WIDTH-1:0]  ADDR,
    input  logic [DATA_WIDTH-1:0]  DATA,
    input  logic                   READ,
    input  logic                   WRITE,
    input  logic                   TRACE_POP,
    output logic                   TRACE_VALID,
    output logic [ADDR_WIDTH-1:0]  TRACE_ADDR,
    output logic [DATA_WIDTH-1:0]  TRACE_DATA,
    output logic                   TRACE_IS_WR,
    output logic [COUNT_WIDTH-1:0] RD_COUNT,
    output logic [COUNT_WIDTH-1:0] WR_COUNT,
    output logic                   TRACE_OVF,
    output logic                   BUS_ERR,
    output logic                   DONE,
    output logic                   TIMEOUT
);

`ifdef DA_VINCI_BUS_MON_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
`else
    localparam bit WINDOW_EN = 1'b0;
`endif

    localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int QW = $clog2(IDLE_LIMIT + 1);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    mon_state_e      state;
    mon_state_e      state_nxt;
    logic            read_q;
    logic            write_q;
    logic [QW-1:0]   quiet_cnt;
    logic [QW-1:0]   quiet_nxt;
    logic [CW-1:0]   cyc_cnt;
    logic [CW-1:0]   cyc_nxt;
    logic            in_run;
    logic            rd_rise;
    logic            wr_rise;
    logic            rd_txn;
    logic            wr_txn;
    logic            txn;
    logic            bus_err_ev;
    logic            halt;
    logic            tmo;
    logic            arm;
    logic            in_window;
    logic            push_req;
    logic            ovf_ev;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_din;
    logic [EW-1:0]   fifo_dout;

    assign in_run     = (state == ST_RUN);
    assign rd_rise    = READ & ~read_q;
    assign wr_rise    = WRITE & ~write_q;
    assign rd_txn     = in_run & rd_rise & ~WRITE;
    assign wr_txn     = in_run & wr_rise & ~READ;
    assign txn        = rd_txn | wr_txn;
    assign bus_err_ev = in_run & rd_rise & wr_rise;
    assign arm        = START & ~in_run;

    assign quiet_nxt  = txn ? '0 : quiet_cnt + 1'b1;
    assign cyc_nxt    = cyc_cnt + 1'b1;
    assign halt       = in_run & (quiet_nxt == QW'(IDLE_LIMIT));
    assign tmo        = in_run & (cyc_nxt == CW'(MAX_CYCLES));

    assign in_window  = (ADDR >= WIN_LO) && (ADDR <= WIN_HI);
    assign push_req   = txn & (~WINDOW_EN | (wr_txn & in_window));
    assign ovf_ev     = push_req & fifo_full & ~TRACE_POP;
    assign fifo_din   = {ADDR, DATA, wr_txn};

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: START arms from IDLE/STOP, halt or timeout stops a run.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (START)      state_nxt = ST_RUN;
            ST_RUN:  if (halt | tmo) state_nxt = ST_STOP;
            ST_STOP: if (START)      state_nxt = ST_RUN;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Previous-cycle strobe samples for edge detection, tracked in every state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            read_q  <= READ;
            write_q <= WRITE;
        end
    end

    // Counters, watchdogs and sticky flags; cleared when a run is armed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD_COUNT  <= '0;
            WR_COUNT  <= '0;
            quiet_cnt <= '0;
            cyc_cnt   <= '0;
            TRACE_OVF <= 1'b0;
            BUS_ERR   <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else if (arm) begin
            RD_COUNT  <= '0;
            WR_COUNT  <= '0;
            quiet_cnt <= '0;
            cyc_cnt   <= '0;
            TRACE_OVF <= 1'b0;
            BUS_ERR   <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else if (in_run) begin
            if (rd_txn) RD_COUNT <= sat_inc(RD_COUNT);
            if (wr_txn) WR_COUNT <= sat_inc(WR_COUNT);
            quiet_cnt <= quiet_nxt;
            cyc_cnt   <= cyc_nxt;
            TRACE_OVF <= TRACE_OVF | ovf_ev;
            BUS_ERR   <= BUS_ERR | bus_err_ev;
            DONE      <= DONE | halt;
            TIMEOUT   <= TIMEOUT | tmo;
        end
    end

    da_vinci_trace_fifo #(
        .WIDTH (EW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .flush (arm),
        .push  (push_req),
        .din   (fifo_din),
        .pop   (TRACE_POP),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign TRACE_VALID = ~fifo_empty;
    assign TRACE_ADDR  = fifo_dout[EW-1 -: ADDR_WIDTH];
    assign TRACE_DATA  = fifo_dout[DATA_WIDTH:1];
    assign TRACE_IS_WR = fifo_dout[0];

endmodule

// File: tb/tb_da_vinci_bus_monitor.sv
// Directed bench for da_vinci_bus_monitor (MAX_CYCLES overridden to 100).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_da_vinci_bus_monitor;

    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rd;
    logic          wr;
    logic          pop;
    logic          trace_valid;
    logic [AW-1:0] trace_addr;
    logic [DW-1:0] trace_data;
    logic          trace_is_wr;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
    logic          trace_ovf;
    logic          bus_err;
    logic          done;
    logic          timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    da_vinci_bus_monitor #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .TRACE_DEPTH (16),
        .IDLE_LIMIT  (64),
        .MAX_CYCLES  (100)
    ) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .START       (start),
        .ADDR        (addr),
        .DATA        (data),
        .READ        (rd),
        .WRITE       (wr),
        .TRACE_POP   (pop),
        .TRACE_VALID (trace_valid),
        .TRACE_ADDR  (trace_addr),
        .TRACE_DATA  (trace_data),
        .TRACE_IS_WR (trace_is_wr),
        .RD_COUNT    (rd_count),
        .WR_COUNT    (wr_count),
        .TRACE_OVF   (trace_ovf),
        .BUS_ERR     (bus_err),
        .DONE        (done),
        .TIMEOUT     (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rd_pulse(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a; data = d; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_pulse(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a; data = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; addr = '0; data = '0;
        rd = 1'b0; wr = 1'b0; pop = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid",   trace_valid, 0);
        chk("rst_rdcnt",   rd_count, 0);
        chk("rst_wrcnt",   wr_count, 0);
        chk("rst_flags",   {trace_ovf, bus_err, done, timeout}, 0);
        chk("rst_trace",   {trace_addr, trace_data, trace_is_wr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three reads traced in order; START while running is ignored
        pulse_start();
        rd_pulse(26'h10, 32'hA0);
        rd_pulse(26'h11, 32'hA1);
        rd_pulse(26'h12, 32'hA2);
        chk("t1_rdcnt", rd_count, 3);
        chk("t1_wrcnt", wr_count, 0);
        pulse_start();
        chk("t1_start_in_run", rd_count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_valid", trace_valid, 1);
            chk("t1_addr",  trace_addr, 64'h10 + i);
            chk("t1_data",  trace_data, 64'hA0 + i);
            chk("t1_iswr",  trace_is_wr, 0);
            pop_one();
        end
        chk("t1_empty", trace_valid, 0);
        pop_one();
        chk("t1_pop_empty", trace_valid, 0);

        // Write strobe held high for five cycles counts once
        do_reset();
        pulse_start();
        addr = 26'h20; data = 32'hDEADBEEF; wr = 1'b1;
        repeat (5) @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        chk("t2_wrcnt", wr_count, 1);
        chk("t2_entry", {trace_valid, trace_addr, trace_data, trace_is_wr},
            {1'b1, 26'h20, 32'hDEADBEEF, 1'b1});
        pop_one();
        chk("t2_empty", trace_valid, 0);

        // Twenty writes into a 16-deep FIFO overflow; the first 16 remain
        do_reset();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            wr_pulse(AW'(i), 32'h1000 + i);
            if (i == 15) chk("t3_no_ovf_at_16", trace_ovf, 0);
        end
        chk("t3_ovf",   trace_ovf, 1);
        chk("t3_wrcnt", wr_count, 20);
        for (int i = 0; i < 16; i++) begin
            chk("t3_addr", trace_addr, i);
            chk("t3_data", trace_data, 32'h1000 + i);
            pop_one();
        end
        chk("t3_empty", trace_valid, 0);

        // Push with simultaneous pop while full succeeds without overflow
        do_reset();
        pulse_start();
        for (int i = 0; i < 16; i++) wr_pulse(AW'(12'h100 + i), 32'h0);
        addr = 26'h200; data = 32'h55; wr = 1'b1; pop = 1'b1;
        @(negedge clk);
        wr = 1'b0; pop = 1'b0;
        @(negedge clk);
        chk("t3b_ovf",   trace_ovf, 0);
        chk("t3b_head",  trace_addr, 26'h101);
        chk("t3b_wrcnt", wr_count, 17);
        repeat (15) pop_one();
        chk("t3b_tail",  {trace_valid, trace_addr, trace_data}, {1'b1, 26'h200, 32'h55});

        // Idle halt after 64 quiet cycles
        do_reset();
        pulse_start();
        repeat (63) @(negedge clk);
        chk("t4_done_63", done, 0);
        @(negedge clk);
        chk("t4_done_64", done, 1);
        chk("t4_timeout", timeout, 0);
        rd_pulse(26'h30, 32'h1);
        chk("t4_stop_ignores_read", rd_count, 0);
        pulse_start();
        chk("t4_restart_clears_done", done, 0);

        // Simultaneous read and write edges flag a bus error only
        do_reset();
        pulse_start();
        addr = 26'h40; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("t5_buserr", bus_err, 1);
        chk("t5_counts", {rd_count, wr_count}, 0);
        chk("t5_valid",  trace_valid, 0);

        // Continuous traffic hits the 100-cycle budget
        do_reset();
        pulse_start();
        for (int i = 0; i < 99; i++) begin
            addr = AW'(i); rd = (i % 2 == 0);
            @(negedge clk);
        end
        rd = 1'b0;
        chk("t6_timeout_99", timeout, 0);
        chk("t6_rdcnt", rd_count, 50);
        @(negedge clk);
        chk("t6_timeout_100", timeout, 1);
        chk("t6_done", done, 0);
        rd_pulse(26'h50, 32'h2);
        chk("t6_stop_rdcnt", rd_count, 50);

        // Address window filter on traced writes
        do_reset();
        pulse_start();
        wr_pulse(26'h3fffff5, 32'h11);
        wr_pulse(26'h0000100, 32'h22);
        chk("t7_wrcnt", wr_count, 2);
        chk("t7_head",  trace_addr, 26'h3fffff5);
        pop_one();
`ifdef DA_VINCI_BUS_MON_WINDOW_EN
        chk("t7_only_one", trace_valid, 0);
`else
        chk("t7_second", {trace_valid, trace_addr}, {1'b1, 26'h0000100});
`endif

        // Asynchronous reset mid-stream clears everything at once
        wr_pulse(26'h3fffff8, 32'h33);
        addr = 26'h3fffff9; wr = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t8_counts", {rd_count, wr_count}, 0);
        chk("t8_trace",  {trace_valid, trace_addr, trace_data, trace_is_wr}, 0);
        chk("t8_flags",  {trace_ovf, bus_err, done, timeout}, 0);
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/da_vinci_bus_monitor.md
DA_VINCI_BUS_MONITOR -- requirements
Module: da_vinci_bus_monitor

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 32, bus data width.
REQ-002 ADDR_WIDTH, 26, bus address width.
REQ-003 TRACE_DEPTH, 16, trace FIFO entries, power of two, at least 2.
REQ-004 IDLE_LIMIT, 64, consecutive quiet RUN cycles that signal a halt.
REQ-005 MAX_CYCLES, 5000, total RUN cycle budget before timeout.
REQ-006 WIN_LO and WIN_HI, 'h03fffff0 and 'h03ffffff, inclusive address window used by the configuration feature.
REQ-007 Ports SHALL be (name  direction  width  meaning): CLK  in  1  single clock, rising edge.
REQ-008 RST  in  1  reset, asynchronous, active-low.
REQ-009 START  in  1  one-cycle pulse that arms monitoring.
REQ-010 ADDR  in  ADDR_WIDTH  observed bus address.
REQ-011 DATA  in  DATA_WIDTH  observed bus data.
REQ-012 READ / WRITE  in  1 each  observed bus strobes.
REQ-013 TRACE_POP  in  1  consume the head trace entry.
REQ-014 TRACE_VALID  out  1  trace FIFO not empty.
REQ-015 TRACE_ADDR / TRACE_DATA / TRACE_IS_WR  out  ADDR_WIDTH / DATA_WIDTH / 1  head entry, first-word-fall-through.
REQ-016 RD_COUNT / WR_COUNT  out  32 each  transaction counters.
REQ-017 TRACE_OVF / BUS_ERR / DONE / TIMEOUT  out  1 each  sticky status flags.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and STOP.
- IDLE->RUN on START.
- RUN->STOP on halt or timeout.
- STOP->RUN on START.
- START in RUN SHALL be ignored.
REQ-019 On IDLE->RUN or STOP->RUN, counters, status flags and watchdogs SHALL clear and the FIFO SHALL flush in the same edge.
REQ-020 A read transaction SHALL be a 0->1 edge of READ (previous-cycle sample 0, current 1) while WRITE=0, in RUN only; writes likewise. Strobes held high count once.
REQ-021 A transaction SHALL increment its counter and push {ADDR, DATA, type}, sampled in the edge cycle. Counter and FIFO update one cycle after the edge.
REQ-022 Simultaneous READ and WRITE rising edges SHALL set BUS_ERR; nothing is counted or pushed.
REQ-023 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-024 Quiet counter: reset to 0 on any transaction, incremented otherwise. On reaching IDLE_LIMIT, go to STOP and set DONE=1.
REQ-025 Cycle counter: counts RUN cycles. On reaching MAX_CYCLES, go to STOP and set TIMEOUT=1. If halt and timeout occur on the same edge, both DONE and TIMEOUT SHALL set.
REQ-026 FIFO push when full SHALL drop the new entry and set TRACE_OVF. Push and pop on the same cycle while full SHALL succeed with no overflow.
REQ-027 Pop when empty SHALL be ignored. Pops SHALL be honoured in every state.
REQ-028 Transactions in IDLE or STOP SHALL be ignored.

Reset
REQ-029 RST low SHALL immediately force: state IDLE, FIFO empty, all counters 0, all outputs 0 (TRACE_* outputs 0).
REQ-030 Reset asserted mid-RUN SHALL discard all state; no partial update survives.

Configuration
REQ-031 With DA_VINCI_BUS_MON_WINDOW_EN defined, only WRITE transactions with WIN_LO <= ADDR <= WIN_HI SHALL be pushed to the trace FIFO. Counters and watchdogs are unaffected.
REQ-032 Without DA_VINCI_BUS_MON_WINDOW_EN, every valid transaction SHALL be pushed.

Structure
REQ-033 FSM state encodings and default parameter values SHALL live in the shared definitions include alongside the project width constants.
REQ-034 The trace FIFO SHALL be one sub-module, da_vinci_trace_fifo: parametrised width and depth, FWFT, full/empty outputs.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset then START; READ pulses at 0x10, 0x11, 0x12 -> RD_COUNT=3; FIFO holds 3 entries in order; WR_COUNT=0.
- WRITE held high for 5 cycles at 0x20 with DATA=0xDEADBEEF -> WR_COUNT=1; one entry (0x20, 0xDEADBEEF, IS_WR=1).
- 20 writes with TRACE_DEPTH=16 and no pops -> TRACE_OVF=1; first 16 entries retained; WR_COUNT=20.
- No activity for IDLE_LIMIT=64 cycles after START -> DONE=1 on cycle 64; state STOP; TIMEOUT=0. A further READ does not count.
- READ and WRITE rise together -> BUS_ERR=1; counters unchanged. Separately, MAX_CYCLES=100 with continuous traffic -> TIMEOUT=1.
- With DA_VINCI_BUS_MON_WINDOW_EN defined, writes to 0x03fffff5 and 0x00000100 -> one FIFO entry (0x03fffff5); WR_COUNT=2. RST low mid-stream -> all outputs 0 immediately.
